// File: rtl/prevencion_pkg.sv
// Shared state encoding and threshold helpers for the prevention FSM.
package prevencion_pkg;

  typedef enum logic [1:0] {
    NORMAL = 2'b00,
    VENT   = 2'b01,
    ALARM  = 2'b10,
    HOLD   = 2'b11
  } state_t;

  // Release thresholds must never wrap below zero.
  function automatic int sat_sub(input int a, input int b);
    return (a > b) ? (a - b) : 0;
  endfunction

endpackage

// File: rtl/prevencion_fsm_param_antirrebote.sv
// Input debouncer: the output flips only after the raw input has differed
// from it for DEB_CYCLES consecutive clock edges.
module antirrebote #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      db  <= 1'b0;
      cnt <= '0;
    end else if (raw != db) begin
      if (cnt == CNT_LAST) begin
        db  <= raw;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else begin
      cnt <= '0;
    end
  end

endmodule

// File: rtl/prevencion_fsm_param.sv
// Prevention unit: temperature/presence/ignition FSM with hysteresis,
// debounced sensors, alarm hold with acknowledge and an alarm-entry counter.
module prevencion_fsm_param
  import prevencion_pkg::*;
#(
  parameter int TEMP_W     = 8,
  parameter int T_WARN     = 28,
  parameter int T_ALARM    = 30,
  parameter int HYST       = 1,
  parameter int DEB_CYCLES = 4,
  parameter int ALARM_HOLD = 16,
  parameter int EVT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [TEMP_W-1:0] temp,
  input  logic              temp_valid,
  input  logic              presencia,
  input  logic              ignicion,
  input  logic              ack,
  output logic              alarma,
  output logic              ventilador,
  output logic [1:0]        estado,
  output logic [EVT_W-1:0]  alarm_events
);

  localparam logic [TEMP_W-1:0] TH_WARN      = TEMP_W'(T_WARN);
  localparam logic [TEMP_W-1:0] TH_ALARM     = TEMP_W'(T_ALARM);
  localparam logic [TEMP_W-1:0] TH_WARN_REL  = TEMP_W'(sat_sub(T_WARN, HYST));
  localparam logic [TEMP_W-1:0] TH_ALARM_REL = TEMP_W'(sat_sub(T_ALARM, HYST));
  localparam int              HW         = (ALARM_HOLD > 1) ? $clog2(ALARM_HOLD) : 1;
  localparam logic [HW-1:0]   HOLD_LOAD  = HW'(ALARM_HOLD - 1);

  logic [TEMP_W-1:0] temp_q;
  logic              pres_db;
  logic              ign_db;
  logic [HW-1:0]     hold_cnt;
  state_t            state;
  state_t            nxt;
  logic              alarm_cond;
  logic              alarm_clear;
  logic              warn_set;
  logic              warn_clear;
  logic              evt;

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pres (
    .clk   (clk),
    .reset (reset),
    .raw   (presencia),
    .db    (pres_db)
  );

  antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ign (
    .clk   (clk),
    .reset (reset),
    .raw   (ignicion),
    .db    (ign_db)
  );

  always_comb begin
    alarm_cond  = ign_db | (pres_db & (temp_q >= TH_ALARM));
    alarm_clear = ~ign_db & (~pres_db | (temp_q < TH_ALARM_REL));
    warn_set    = temp_q >= TH_WARN;
    warn_clear  = temp_q < TH_WARN_REL;

    nxt = state;
    case (state)
      NORMAL: begin
        if (alarm_cond)    nxt = ALARM;
        else if (warn_set) nxt = VENT;
      end
      VENT: begin
        if (alarm_cond)      nxt = ALARM;
        else if (warn_clear) nxt = NORMAL;
      end
      ALARM: begin
        if (alarm_clear && (hold_cnt == '0)) nxt = HOLD;
      end
      HOLD: begin
        if (alarm_cond) nxt = ALARM;
        else if (ack)   nxt = warn_clear ? NORMAL : VENT;
      end
      default: nxt = NORMAL;
    endcase

    // Only fresh entries count; re-arming from HOLD is the same incident.
    evt = (nxt == ALARM) && ((state == NORMAL) || (state == VENT));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      temp_q       <= '0;
      state        <= NORMAL;
      hold_cnt     <= '0;
      alarm_events <= '0;
      alarma       <= 1'b0;
      ventilador   <= 1'b0;
    end else begin
      if (temp_valid) temp_q <= temp;
      state      <= nxt;
      alarma     <= (nxt == ALARM) || (nxt == HOLD);
      ventilador <= (nxt != NORMAL);
      // Load on entry and while the condition persists; count down once it clears.
      if (nxt == ALARM) begin
        if ((state != ALARM) || !alarm_clear) hold_cnt <= HOLD_LOAD;
        else if (hold_cnt != '0)              hold_cnt <= hold_cnt - 1'b1;
      end
      if (evt && (alarm_events != '1)) alarm_events <= alarm_events + 1'b1;
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_prevencion_fsm_param.sv
// Directed self-checking bench for prevencion_fsm_param (default and EVT_W=2).
module tb_prevencion_fsm_param;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] temp;
  logic       temp_valid;
  logic       presencia;
  logic       ignicion;
  logic       ack;
  logic       alarma, ventilador;
  logic [1:0] estado;
  logic [7:0] alarm_events;
  logic       a2, v2;
  logic [1:0] e2;
  logic [1:0] ev2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  prevencion_fsm_param dut (
    .clk          (clk),
    .reset        (reset),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .presencia    (presencia),
    .ignicion     (ignicion),
    .ack          (ack),
    .alarma       (alarma),
    .ventilador   (ventilador),
    .estado       (estado),
    .alarm_events (alarm_events)
  );

  prevencion_fsm_param #(.EVT_W(2)) dut2 (
    .clk          (clk),
    .reset        (reset),
    .temp         (temp),
    .temp_valid   (temp_valid),
    .presencia    (presencia),
    .ignicion     (ignicion),
    .ack          (ack),
    .alarma       (a2),
    .ventilador   (v2),
    .estado       (e2),
    .alarm_events (ev2)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  initial begin
    reset = 1'b0; temp = 8'd0; temp_valid = 1'b0;
    presencia = 1'b0; ignicion = 1'b1; ack = 1'b0;

    // Reset held with ignition active
    tick(3);
    check("rst_alarma", 8'(alarma), 8'd0);
    check("rst_vent", 8'(ventilador), 8'd0);
    check("rst_estado", 8'(estado), 8'd0);
    check("rst_events", alarm_events, 8'd0);
    check("rst_alarma2", 8'(a2), 8'd0);
    check("rst_vent2", 8'(v2), 8'd0);

    // Release: ALARM exactly DEB_CYCLES+1 edges later
    reset = 1'b1;
    tick(4);
    check("ign_not_yet", 8'(estado), 8'd0);
    tick(1);
    check("ign_alarm", 8'(estado), 8'd2);
    check("ign_alarma", 8'(alarma), 8'd1);
    check("ign_events", alarm_events, 8'd1);

    // Drop ignition; ack during ALARM must be ignored
    ignicion = 1'b0;
    tick(9);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    tick(9);
    check("hold_last_alarm", 8'(estado), 8'd2);
    tick(1);
    check("hold_entered", 8'(estado), 8'd3);
    check("hold_alarma", 8'(alarma), 8'd1);
    check("hold_vent", 8'(ventilador), 8'd1);

    // Re-trigger from HOLD: no new event
    ignicion = 1'b1;
    tick(4);
    check("retrig_wait", 8'(estado), 8'd3);
    tick(1);
    check("retrig_alarm", 8'(estado), 8'd2);
    check("retrig_events", alarm_events, 8'd1);
    ignicion = 1'b0;
    tick(20);
    check("retrig_hold", 8'(estado), 8'd3);

    // Ack with cool temperature -> NORMAL
    temp = 8'd20; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    check("hold_no_ack", 8'(estado), 8'd3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_normal", 8'(estado), 8'd0);
    check("ack_alarma", 8'(alarma), 8'd0);
    check("ack_vent", 8'(ventilador), 8'd0);

    // Hysteresis on fan threshold
    temp = 8'd28; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    check("warn_latency", 8'(estado), 8'd0);
    tick(1);
    check("warn_on", 8'(estado), 8'd1);
    temp = 8'd27; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    tick(1);
    check("warn_hyst_27", 8'(estado), 8'd1);
    temp = 8'd26; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    check("warn_26_latency", 8'(estado), 8'd1);
    tick(1);
    check("warn_off", 8'(estado), 8'd0);

    // Presence debounce at 31 degrees
    temp = 8'd31; temp_valid = 1'b1;
    tick(1);
    temp_valid = 1'b0;
    tick(1);
    check("hot_vent", 8'(estado), 8'd1);
    presencia = 1'b1;
    tick(3);
    presencia = 1'b0;
    tick(2);
    check("pres_short", 8'(estado), 8'd1);
    check("pres_short_ev", alarm_events, 8'd1);
    presencia = 1'b1;
    tick(4);
    check("pres_wait", 8'(estado), 8'd1);
    tick(1);
    check("pres_alarm", 8'(estado), 8'd2);
    check("pres_events", alarm_events, 8'd2);
    check("pres_events2", 8'(ev2), 8'd2);
    presencia = 1'b0;
    tick(20);
    check("pres_hold", 8'(estado), 8'd3);
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
    check("ack_hot_vent", 8'(estado), 8'd1);

    // Three more entries: 5 total, the 2-bit counter pins at 3
    repeat (3) begin
      presencia = 1'b1;
      tick(5);
      check("loop_alarm", 8'(e2), 8'd2);
      presencia = 1'b0;
      tick(20);
      check("loop_hold", 8'(estado), 8'd3);
      ack = 1'b1;
      tick(1);
      ack = 1'b0;
      check("loop_vent", 8'(estado), 8'd1);
    end
    check("sat_events8", alarm_events, 8'd5);
    check("sat_events2", 8'(ev2), 8'd3);

    // Reset mid-operation clears everything
    ignicion = 1'b1;
    tick(5);
    check("pre_rst_alarm", 8'(estado), 8'd2);
    reset = 1'b0;
    tick(1);
    check("mid_rst_estado", 8'(estado), 8'd0);
    check("mid_rst_alarma", 8'(alarma), 8'd0);
    check("mid_rst_events", alarm_events, 8'd0);
    check("mid_rst_events2", 8'(ev2), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
